fetch_queue: RTL

//  Parametrised instruction-fetch front end: generates sequential PCs, issues them to a multi-cycle

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_queue.sv | 105 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch front end: HLT opcode, opcode field width, default sizes.
package fetch_pkg;
  localparam int DEF_XLEN    = 16;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_PC_STEP = 2;
  localparam int OP_W        = 4;
  localparam logic [OP_W-1:0] HLT_OP = 4'hF;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush; write-to-read latency 1 cycle, head read combinationally.
// No internal backpressure: the caller never pushes when full or pops when empty; push and pop may coincide.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = count_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: sequential PCs to a multi-cycle imem, in-order responses buffered for IF/ID; rsp-to-ID 1 cycle.
// Requests stall while queued + in-flight reaches DEPTH, on redirect and after HLT; id_ready low holds the head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PC_STEP = DEF_PC_STEP,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_inc,
  output logic            halted
);
  localparam int CNT_W = count_w(DEPTH);
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   rsp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  out_next;
  logic [CNT_W-1:0]  q_count;
  logic [2*XLEN-1:0] q_rdata;
  logic [XLEN-1:0]   head_pc;
  logic              req_fire;
  logic              rsp_drop;
  logic              enq;
  logic              deq;
  logic              hlt_enq;

  assign imem_req_valid = rst_n & ~halted & ~redirect_valid &
                          (({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response landing in a redirect cycle is wrong-path and is discarded like any stale one.
  assign rsp_drop = imem_rsp_valid & ((drop != '0) | redirect_valid);
  assign enq      = imem_rsp_valid & ~rsp_drop;
  assign hlt_enq  = enq & (imem_rsp_data[XLEN-1 -: OP_W] == HLT_OP);
  assign out_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

  assign id_valid = (q_count != '0) & ~redirect_valid;
  assign deq      = id_valid & id_ready;

  // rsp_pc is the PC of the oldest live request; stale responses never advance it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      halted      <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop     <= out_next;
        halted   <= 1'b0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (enq)      rsp_pc   <= rsp_pc + STEP;
        if (hlt_enq) begin
          halted <= 1'b1;
          drop   <= out_next;
        end else if (rsp_drop) begin
          drop <= drop - CNT_W'(1);
        end
      end
    end
  end

  fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (enq),
    .wdata ({imem_rsp_data, rsp_pc}),
    .pop   (deq),
    .rdata (q_rdata),
    .count (q_count)
  );

  assign head_pc   = q_rdata[XLEN-1:0];
  assign id_inst   = id_valid ? q_rdata[2*XLEN-1:XLEN] : '0;
  assign id_pc     = id_valid ? head_pc : '0;
  assign id_pc_inc = id_valid ? head_pc + STEP : '0;

  // The memory answers strictly in order, so a response with nothing in flight is a protocol error.
  assert property (@(posedge clk) disable iff (!rst_n) !(imem_rsp_valid && (outstanding == '0)));
endmodule
